// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for the rename stage.
// One tag is handed out per cycle from the head and one committed tag is
// accepted per cycle at the tail. A single checkpoint of the head pointer
// lets a mispredict reclaim every tag allocated after the branch.
module phys_reg_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             release_valid,
  input  logic [TAG_W-1:0] release_tag,
  input  logic             ckpt_take,
  input  logic             ckpt_restore,
  output logic [TAG_W-1:0] free_count,
  output logic             empty,
  output logic             full,
  output logic             overflow_err
);

  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  // One extra wrap bit distinguishes full (tail-head==DEPTH) from empty.
  localparam int PTR_W = IDX_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0] TAIL_RESET = PTR_W'(DEPTH);
  localparam logic [TAG_W-1:0] CNT_FULL   = TAG_W'(DEPTH);

  // Elaboration-time parameter sanity.
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("phys_reg_free_list: PHYS_REGS-ARCH_REGS must be a power of two");
  end
  if (TAG_W != $clog2(PHYS_REGS)) begin : g_tagw_chk
    $error("phys_reg_free_list: TAG_W must equal clog2(PHYS_REGS)");
  end

  // Pointer, count and error state.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] ckpt_q, ckpt_d;
  logic [TAG_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  // Tag storage.
  logic [TAG_W-1:0] mem_q [DEPTH];

  logic             grant;
  logic             rel_accept;
  logic [PTR_W-1:0] ptr_diff;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Status flags are decoded from the registered count only, so a release
  // never bypasses into a same-cycle grant.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_FULL);
  assign free_count   = count_q;
  assign overflow_err = ovf_q;

  // Restore outranks allocation; nothing is granted while reset is held.
  assign grant       = alloc_req & ~empty & ~ckpt_restore & rst_n;
  assign alloc_grant = grant;
  assign alloc_tag   = mem_q[head_idx];

  // Releases are accepted only while there is room at the tail.
  assign rel_accept = release_valid & ~full;

  // Next-state computation for pointers, checkpoint, count and error flag.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    ckpt_d = ckpt_q;
    ovf_d  = ovf_q;

    if (ckpt_restore) begin
      head_d = ckpt_q;
    end else if (grant) begin
      head_d = head_q + PTR_ONE;
    end

    // The snapshot sees the head after this cycle's grant; a simultaneous
    // restore wins and leaves the snapshot untouched.
    if (ckpt_take && !ckpt_restore) begin
      ckpt_d = head_d;
    end

    if (rel_accept) begin
      tail_d = tail_q + PTR_ONE;
    end

    if (release_valid && full) begin
      ovf_d = 1'b1;
    end

    ptr_diff = tail_d - head_d;
    count_d  = TAG_W'(ptr_diff);
  end

  // Pointer and status registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= TAIL_RESET;
      ckpt_q  <= '0;
      count_q <= CNT_FULL;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      ckpt_q  <= ckpt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Tag array: preloaded with the unmapped tags, written at the tail on release.
  // NOTE: this memory is reset on purpose because the free tags must be
  // ARCH_REGS..PHYS_REGS-1 straight out of reset; it therefore maps to flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(ARCH_REGS + i);
      end
    end else if (rel_accept) begin
      mem_q[tail_idx] <= release_tag;
    end
  end

  // Structural invariants.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_FULL);
  a_grant_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
    alloc_grant |-> !empty);

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 time unit later, registered outputs right after the next edge.
module tb_phys_reg_free_list;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alloc_req;
  logic             alloc_grant;
  logic [TAG_W-1:0] alloc_tag;
  logic             release_valid;
  logic [TAG_W-1:0] release_tag;
  logic             ckpt_take;
  logic             ckpt_restore;
  logic [TAG_W-1:0] free_count;
  logic             empty;
  logic             full;
  logic             overflow_err;

  int checks = 0;
  int errors = 0;

  phys_reg_free_list #(.PHYS_REGS(64), .ARCH_REGS(32), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_tag    (alloc_tag),
    .release_valid(release_valid),
    .release_tag  (release_tag),
    .ckpt_take    (ckpt_take),
    .ckpt_restore (ckpt_restore),
    .free_count   (free_count),
    .empty        (empty),
    .full         (full),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req     = 1'b0;
    release_valid = 1'b0;
    release_tag   = '0;
    ckpt_take     = 1'b0;
    ckpt_restore  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got %0b expected 0", alloc_grant);
    end
    checks++;
    if (free_count !== 6'd32) begin
      errors++; $display("FAIL reset_count: got %0d expected 32", free_count);
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL reset_flags: full=%0b empty=%0b expected full=1 empty=0", full, empty);
    end
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow_err);
    end
    checks++;
    if (alloc_tag !== 6'd32) begin
      errors++; $display("FAIL reset_tag: got %0d expected 32", alloc_tag);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  // Drain all 32 tags in order, then observe the empty cycle.
  task automatic test_alloc_drain();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_grant !== 1'b1 || alloc_tag !== 6'(32 + i)) begin
        errors++;
        $display("FAIL drain_grant[%0d]: grant=%0b tag=%0d expected grant=1 tag=%0d",
                 i, alloc_grant, alloc_tag, 32 + i);
      end
      tick();
    end
    #1;
    checks++;
    if (alloc_grant !== 1'b0 || empty !== 1'b1 || free_count !== 6'd0) begin
      errors++;
      $display("FAIL drain_empty: grant=%0b empty=%0b count=%0d expected 0/1/0",
               alloc_grant, empty, free_count);
    end
  endtask

  // Continues from the empty state left by test_alloc_drain.
  task automatic test_release_empty();
    alloc_req     = 1'b1;
    release_valid = 1'b1;
    release_tag   = 6'd40;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      errors++; $display("FAIL nobypass_grant: got %0b expected 0", alloc_grant);
    end
    tick();
    release_valid = 1'b0;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_tag !== 6'd40 || free_count !== 6'd1) begin
      errors++;
      $display("FAIL relempty_grant: grant=%0b tag=%0d count=%0d expected 1/40/1",
               alloc_grant, alloc_tag, free_count);
    end
    tick();
    alloc_req = 1'b0;
    #1;
    checks++;
    if (free_count !== 6'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL relempty_count: count=%0d empty=%0b expected 0/1", free_count, empty);
    end
    idle_inputs();
  endtask

  task automatic test_checkpoint();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1;
      tick();
    end
    ckpt_take = 1'b1;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_tag !== 6'd35) begin
      errors++;
      $display("FAIL ckpt_take_grant: grant=%0b tag=%0d expected 1/35", alloc_grant, alloc_tag);
    end
    tick();
    ckpt_take = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (alloc_tag !== 6'(36 + i)) begin
        errors++; $display("FAIL ckpt_alloc[%0d]: tag=%0d expected %0d", i, alloc_tag, 36 + i);
      end
      tick();
    end
    ckpt_restore = 1'b1;
    #1;
    checks++;
    if (alloc_grant !== 1'b0) begin
      errors++; $display("FAIL restore_grant: got %0b expected 0", alloc_grant);
    end
    tick();
    ckpt_restore = 1'b0;
    alloc_req    = 1'b0;
    #1;
    checks++;
    if (alloc_tag !== 6'd36 || free_count !== 6'd28) begin
      errors++;
      $display("FAIL restore_state: tag=%0d count=%0d expected 36/28", alloc_tag, free_count);
    end
    // Allocate two more, then restore and take together: back to tag 36.
    alloc_req = 1'b1;
    tick();
    tick();
    ckpt_restore = 1'b1;
    ckpt_take    = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (alloc_tag !== 6'd36 || free_count !== 6'd28) begin
      errors++;
      $display("FAIL restore_take: tag=%0d count=%0d expected 36/28", alloc_tag, free_count);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1;
      tick();
    end
    release_valid = 1'b1;
    release_tag   = 6'd5;
    #1;
    checks++;
    if (alloc_grant !== 1'b1 || alloc_tag !== 6'd36) begin
      errors++;
      $display("FAIL simul_grant: grant=%0b tag=%0d expected 1/36", alloc_grant, alloc_tag);
    end
    tick();
    release_valid = 1'b0;
    alloc_req     = 1'b0;
    #1;
    checks++;
    if (free_count !== 6'd28) begin
      errors++; $display("FAIL simul_count: got %0d expected 28", free_count);
    end
    // Remaining tags 37..63, then the released tag 5 from the old tail slot.
    for (int i = 0; i < 28; i++) begin
      logic [TAG_W-1:0] exp_tag;
      exp_tag   = (i < 27) ? 6'(37 + i) : 6'd5;
      alloc_req = 1'b1;
      #1;
      checks++;
      if (alloc_grant !== 1'b1 || alloc_tag !== exp_tag) begin
        errors++;
        $display("FAIL simul_drain[%0d]: grant=%0b tag=%0d expected 1/%0d",
                 i, alloc_grant, alloc_tag, exp_tag);
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL simul_empty: got %0b expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    release_valid = 1'b1;
    release_tag   = 6'd7;
    tick();
    release_valid = 1'b0;
    #1;
    checks++;
    if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
      errors++;
      $display("FAIL ovf_set: ovf=%0b count=%0d expected 1/32", overflow_err, free_count);
    end
    alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_tag !== 6'd32) begin
      errors++; $display("FAIL ovf_tag: got %0d expected 32", alloc_tag);
    end
    tick();
    alloc_req     = 1'b0;
    release_valid = 1'b1;
    release_tag   = 6'd9;
    tick();
    release_valid = 1'b0;
    #1;
    checks++;
    if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%0b count=%0d expected 1/32", overflow_err, free_count);
    end
    // Reset with pending inputs clears everything.
    rst_n         = 1'b0;
    alloc_req     = 1'b1;
    release_valid = 1'b1;
    release_tag   = 6'd3;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if (overflow_err !== 1'b0 || free_count !== 6'd32 || alloc_tag !== 6'd32) begin
      errors++;
      $display("FAIL ovf_reset: ovf=%0b count=%0d tag=%0d expected 0/32/32",
               overflow_err, free_count, alloc_tag);
    end
  endtask

  task automatic test_wrap();
    logic [TAG_W-1:0] free_q [$];
    logic [TAG_W-1:0] held_q [$];
    logic [TAG_W-1:0] got;
    logic             exp_grant;
    bit               seen [64];
    int               bad;
    do_reset();
    for (int t = 32; t < 64; t++) free_q.push_back(6'(t));
    for (int i = 0; i < 100; i++) begin
      alloc_req     = ((i % 3) != 0);
      release_valid = (held_q.size() > 0) && (((i % 2) == 0) || (held_q.size() > 24));
      release_tag   = release_valid ? held_q[0] : '0;
      #1;
      exp_grant = alloc_req && (free_q.size() > 0);
      checks++;
      if (alloc_grant !== exp_grant || free_count !== 6'(free_q.size()) ||
          (exp_grant && alloc_tag !== free_q[0])) begin
        errors++;
        $display("FAIL wrap[%0d]: grant=%0b tag=%0d count=%0d expected grant=%0b tag=%0d count=%0d",
                 i, alloc_grant, alloc_tag, free_count, exp_grant,
                 exp_grant ? free_q[0] : alloc_tag, free_q.size());
      end
      if (exp_grant) begin
        got = free_q.pop_front();
        held_q.push_back(got);
      end
      if (release_valid) begin
        got = held_q.pop_front();
        free_q.push_back(got);
      end
      tick();
    end
    idle_inputs();
    while (held_q.size() > 0) begin
      release_valid = 1'b1;
      release_tag   = held_q.pop_front();
      tick();
    end
    release_valid = 1'b0;
    #1;
    checks++;
    if (free_count !== 6'd32 || full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_refill: count=%0d full=%0b expected 32/1", free_count, full);
    end
    for (int t = 0; t < 64; t++) seen[t] = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      alloc_req = 1'b1;
      #1;
      if (alloc_grant !== 1'b1 || alloc_tag < 6'd32 || seen[alloc_tag]) bad++;
      else seen[alloc_tag] = 1'b1;
      tick();
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_unique: %0d lost or duplicated tags, expected 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc_drain();
    test_release_empty();
    test_checkpoint();
    test_simultaneous();
    test_overflow();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
